// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front end: opcodes, loader state encoding,
// and the operand-count rule used by the loader and later sequential stages.
package alu_pkg;

  localparam logic [3:0] OP_MUL  = 4'd7;
  localparam logic [3:0] OP_DIV  = 4'd8;
  localparam logic [3:0] OP_LAST = 4'd8;

  typedef enum logic [1:0] {
    ST_CMD   = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ISSUE = 2'd2
  } ld_state_e;

  // MUL and DIV take four operands; every other legal op takes two.
  function automatic logic [2:0] opnd_count(input logic [3:0] op);
    return ((op == OP_MUL) || (op == OP_DIV)) ? 3'd4 : 3'd2;
  endfunction

endpackage

// File: rtl/alu_operand_loader_if.sv
// Bundle of the loader's input stream and its operand-set output handshake.
// slave  = loader side, master = upstream feeder / math-stage side.
interface alu_operand_loader_if #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 4
);

  logic [DATA_W-1:0] i_data;
  logic              i_valid;
  logic              o_ready;
  logic [OP_W-1:0]   o_op;
  logic              o_mode;
  logic [DATA_W-1:0] o_A;
  logic [DATA_W-1:0] o_B;
  logic [DATA_W-1:0] o_C;
  logic [DATA_W-1:0] o_D;
  logic              o_valid;
  logic              i_ready;
  logic              o_div0;
  logic              o_err;

  modport slave (
    input  i_data, i_valid, i_ready,
    output o_ready, o_op, o_mode, o_A, o_B, o_C, o_D, o_valid, o_div0, o_err
  );

  modport master (
    output i_data, i_valid, i_ready,
    input  o_ready, o_op, o_mode, o_A, o_B, o_C, o_D, o_valid, o_div0, o_err
  );

endinterface

// File: rtl/alu_operand_loader.sv
// Collects a command word plus two or four operands from a narrow stream and
// presents a complete, stable operand set to the math unit. Illegal opcodes
// are dropped with a one-cycle error pulse; DIV sets are pre-flagged for a
// zero divisor so the combinational math stage never sees a bad set.
module alu_operand_loader #(
  parameter int              DATA_W  = 16,
  parameter int              OP_W    = 4,
  parameter logic [OP_W-1:0] OP_LAST = OP_W'(8)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  alu_operand_loader_if.slave  bus
);

  import alu_pkg::*;

  ld_state_e         state_q, state_d;
  logic [OP_W-1:0]   op_q,    op_d;
  logic              mode_q,  mode_d;
  logic [DATA_W-1:0] opnd_q [4];
  logic [DATA_W-1:0] opnd_d [4];
  logic [1:0]        cnt_q,   cnt_d;
  logic              valid_q, valid_d;
  logic              div0_q,  div0_d;
  logic              err_q,   err_d;

  logic              ready;
  logic              accept;
  logic [OP_W-1:0]   cmd_op;
  logic [2:0]        need;
  logic              div0_calc;

  // Ready depends on state only; held low while reset is asserted.
  assign ready  = i_rst_n && ((state_q == ST_CMD) || (state_q == ST_LOAD));
  assign accept = bus.i_valid && ready;
  assign cmd_op = bus.i_data[OP_W-1:0];
  assign need   = opnd_count(op_q);

  // Next-state, operand capture and flag computation.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    mode_d    = mode_q;
    opnd_d    = opnd_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    div0_d    = div0_q;
    err_d     = 1'b0;
    div0_calc = 1'b0;

    case (state_q)
      ST_CMD: begin
        if (accept) begin
          if (cmd_op > OP_LAST) begin
            // Drop the command; previous outputs stay as they were.
            err_d = 1'b1;
          end else begin
            op_d   = cmd_op;
            mode_d = bus.i_data[OP_W];
            for (int i = 0; i < 4; i++) opnd_d[i] = '0;
            cnt_d   = 2'd0;
            state_d = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (accept) begin
          opnd_d[cnt_q] = bus.i_data;
          cnt_d         = cnt_q + 2'd1;
          if ({1'b0, cnt_q} == (need - 3'd1)) begin
            // Zero-divisor check on the set as it will be registered,
            // including the operand arriving this cycle.
            if (op_q == OP_DIV) begin
              if (mode_q) div0_calc = (opnd_d[2] == '0) && (opnd_d[3] == '0);
              else        div0_calc = (opnd_d[1] == '0) || (opnd_d[3] == '0);
            end
            div0_d  = div0_calc;
            valid_d = 1'b1;
            state_d = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        if (bus.i_ready) begin
          valid_d = 1'b0;
          div0_d  = 1'b0;
          state_d = ST_CMD;
        end
      end

      default: begin
        state_d = ST_CMD;
      end
    endcase
  end

  // State and operand registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_CMD;
      op_q    <= '0;
      mode_q  <= 1'b0;
      for (int i = 0; i < 4; i++) opnd_q[i] <= '0;
      cnt_q   <= 2'd0;
      valid_q <= 1'b0;
      div0_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mode_q  <= mode_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      div0_q  <= div0_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_ready = ready;
  assign bus.o_op    = op_q;
  assign bus.o_mode  = mode_q;
  assign bus.o_A     = opnd_q[0];
  assign bus.o_B     = opnd_q[1];
  assign bus.o_C     = opnd_q[2];
  assign bus.o_D     = opnd_q[3];
  assign bus.o_valid = valid_q;
  assign bus.o_div0  = div0_q;
  assign bus.o_err   = err_q;

endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
Upstream feeder for the ALU math unit. It collects one command word and then two or four 16-bit operands, beat by beat, from a narrow valid/ready stream. It then presents a stable, complete operand set (op, mode, A, B, C, D) to the math unit with a valid/ready handshake. It also pre-flags divide-by-zero and illegal opcodes, so the combinational math stage never sees a partial or illegal set.

Parameters:
DATA_W, 16, width of the input stream word and of each operand A/B/C/D
OP_W, 4, opcode width
OP_LAST, 8, highest legal opcode (codes 0..8 legal; 7 = MUL, 8 = DIV)

Ports:
i_clk  input  1  clock, all logic on rising edge
i_rst_n  input  1  reset, synchronous, active-low
i_data  input  DATA_W  stream word (command or operand)
i_valid  input  1  i_data valid
o_ready  output  1  loader can accept a word this cycle
o_op  output  OP_W  captured opcode
o_mode  output  1  captured mode (0 simple, 1 complex)
o_A, o_B, o_C, o_D  output  DATA_W each  captured operands
o_valid  output  1  operand set complete and stable
i_ready  input  1  math stage consumes the set this cycle
o_div0  output  1  set is DIV with zero divisor; qualified by o_valid
o_err  output  1  one-cycle pulse: illegal opcode dropped

Behaviour:
- Reset and clocking:
  - One clock, i_clk. Reset i_rst_n is synchronous and active-low, sampled on the i_clk rising edge.
  - While reset is sampled low: state <- CMD, o_valid/o_div0/o_err = 0, o_op/o_mode/o_A..o_D = 0, count = 0.
  - Reset mid-load or mid-issue discards the partial or pending set.
- Transfers:
  - Input beat accepted when i_valid && o_ready at the edge.
  - Output set consumed when o_valid && i_ready at the edge.
- o_ready: combinational from state only. 1 in CMD and LOAD; 0 in ISSUE and during reset. Never depends on i_valid.
- State CMD:
  - On an accepted beat, capture op = i_data[3:0] and mode = i_data[4]; i_data[15:5] ignored.
  - If op > OP_LAST: o_err = 1 for exactly the next cycle; stay in CMD; outputs unchanged.
  - Else: clear A..D to 0, count = 0, need = 4 if op is 7 or 8, else 2; go to LOAD.
- State LOAD:
  - Each accepted beat writes operand[count] (order A, B, C, D) and increments count.
  - On the beat where count == need-1, go to ISSUE. o_valid rises the next cycle, which is a latency of 1 cycle after the last operand beat.
  - No beats during LOAD: wait indefinitely, no timeout.
  - For two-operand ops, C and D stay 0.
- o_div0: registered alongside o_valid, computed from the captured values.
  - op 8, mode 0: o_div0 = (B == 0) || (D == 0).
  - op 8, mode 1: o_div0 = (C == 0) && (D == 0).
  - Any other op: o_div0 = 0.
- State ISSUE:
  - o_op, o_mode, o_A..o_D, o_div0 held stable while o_valid = 1.
  - On handshake: next cycle o_valid = 0, state CMD. o_div0 cleared.
  - No bypass: the next command beat is accepted at the earliest one cycle after the handshake edge.
  - Best-case throughput per set: 1 + need + 1 cycles.
- Mode is captured for every legal op, including ops 0..6, where the math unit ignores it.
- i_data/i_valid while o_ready = 0: ignored, no capture.

Decomposition:
- Shared package alu_pkg:
  - opcode constants OP_MUL = 4'd7, OP_DIV = 4'd8, OP_LAST;
  - loader state encoding (CMD, LOAD, ISSUE; 2-bit);
  - a function returning operand count for an opcode (2 or 4), reused by later sequential math stages.
- No sub-module. A single FSM plus operand registers is natural.
- Divide-by-zero logic stays inline, about 5 lines.

Test Plan:
- Simple op, reset: reset 3 cycles, then beats 0x0000 (op 0), 0x0005, 0x0003 with i_ready = 1 -> o_valid for exactly 1 cycle, 1 cycle after beat 3; A = 5, B = 3, C = D = 0; o_div0 = 0.
- Complex MUL with backpressure: beats 0x0017 (mode 1, op 7), 1, 2, 3, 4; hold i_ready = 0 for 5 cycles -> outputs stable; o_ready = 0 throughout; after i_ready, o_valid drops and o_ready = 1 the next cycle.
- Divide by zero: beats 0x0008, 10, 0, 6, 2 -> o_div0 = 1. Complex DIV 0x0018, 1, 1, 0, 0 -> o_div0 = 1. Complex DIV 0x0018, 1, 1, 0, 4 -> o_div0 = 0.
- Illegal opcode: beat 0x000C -> o_err high exactly 1 cycle; state stays CMD. A following beat 0x0007 is accepted as a command and needs 4 operands.
- Bubbles and ignored beats: beats with i_valid toggling 1/0 -> only valid beats captured, in order. Beats while in ISSUE are not captured.
- Reset mid-load: after command 0x0007 and 2 operands, pull i_rst_n low 1 cycle -> all outputs 0, o_ready = 1. A fresh op-0 set then completes normally.
